// File: rtl/la_debounce.sv
// Glitch filter + edge detector: out follows in after HOLD tick-qualified cycles.
// Latency HOLD+1 edges at tick=1; no backpressure, all outputs registered.
module la_debounce #(
    parameter        PROP   = "DEFAULT",
    parameter int    HOLD   = 8,
    parameter bit    RSTVAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_d, rise_d, fall_d, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            out     <= RSTVAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out     <= out_d;
            rise    <= rise_d;
            fall    <= fall_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        busy_d  = busy;
        case (state_q)
            STABLE: begin
                if (in != out) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CHECK: begin
                // Rejection is tested before tick so a glitch on the commit edge never commits.
                if (in == out) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        out_d   = ~out;
                        rise_d  = ~out;
                        fall_d  = out;
                        state_d = STABLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_la_debounce.sv
// Four debouncer configurations driven side by side against a per-cycle reference model.
module tb_la_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din, tck;
    logic [3:0] dout, drise, dfall, dbusy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 0: HOLD=8 RSTVAL=0, 1: HOLD=4, 2: HOLD=1, 3: HOLD=3 RSTVAL=1
    la_debounce #(.PROP("DEFAULT"), .HOLD(8), .RSTVAL(1'b0)) u_h8 (
        .clk(clk), .reset(reset), .tick(tck[0]), .in(din[0]),
        .out(dout[0]), .rise(drise[0]), .fall(dfall[0]), .busy(dbusy[0]));
    la_debounce #(.PROP("DEFAULT"), .HOLD(4), .RSTVAL(1'b0)) u_h4 (
        .clk(clk), .reset(reset), .tick(tck[1]), .in(din[1]),
        .out(dout[1]), .rise(drise[1]), .fall(dfall[1]), .busy(dbusy[1]));
    la_debounce #(.PROP("DEFAULT"), .HOLD(1), .RSTVAL(1'b0)) u_h1 (
        .clk(clk), .reset(reset), .tick(tck[2]), .in(din[2]),
        .out(dout[2]), .rise(drise[2]), .fall(dfall[2]), .busy(dbusy[2]));
    la_debounce #(.PROP("DEFAULT"), .HOLD(3), .RSTVAL(1'b1)) u_r1 (
        .clk(clk), .reset(reset), .tick(tck[3]), .in(din[3]),
        .out(dout[3]), .rise(drise[3]), .fall(dfall[3]), .busy(dbusy[3]));

    typedef struct {
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] busy;
    } exp_t;

    exp_t sbq[$];

    int         hold_p[4] = '{8, 4, 1, 3};
    logic       rstv_p[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] m_out  = '0;
    logic [3:0] m_rise = '0;
    logic [3:0] m_fall = '0;
    logic [3:0] m_busy = '0;
    int         m_ticks[4] = '{0, 0, 0, 0};

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    // Reference: count tick-qualified edges seen while in differs from out; toggle when HOLD reached.
    task automatic model_edge();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (reset) begin
                m_out[i]   = rstv_p[i];
                m_busy[i]  = 1'b0;
                m_ticks[i] = 0;
            end else if (!m_busy[i]) begin
                if (din[i] != m_out[i]) begin
                    m_busy[i]  = 1'b1;
                    m_ticks[i] = 0;
                end
            end else if (din[i] == m_out[i]) begin
                m_busy[i] = 1'b0;
            end else if (tck[i]) begin
                m_ticks[i]++;
                if (m_ticks[i] == hold_p[i]) begin
                    m_out[i]   = ~m_out[i];
                    m_rise[i]  = m_out[i];
                    m_fall[i]  = ~m_out[i];
                    m_busy[i]  = 1'b0;
                    m_ticks[i] = 0;
                end
            end
        end
        e.out  = m_out;
        e.rise = m_rise;
        e.fall = m_fall;
        e.busy = m_busy;
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        e = sbq.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk("out", i, dout[i], e.out[i]);
            chk("rise", i, drise[i], e.rise[i]);
            chk("fall", i, dfall[i], e.fall[i]);
            chk("busy", i, dbusy[i], e.busy[i]);
        end
        chk("rise_and_fall", 0, |(drise & dfall), 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        din   = 4'b1000;
        tck   = 4'b1111;

        // Reset state
        step();
        chk("rst_out", 0, dout[0], 1'b0);
        chk("rst_out", 3, dout[3], 1'b1);
        chk("rst_busy", 0, dbusy[0], 1'b0);
        reset = 1'b0;
        step();
        step();

        // Clean rise then fall on HOLD=8
        din[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) chk("rise_busy_e1", 0, dbusy[0], 1'b1);
            if (k == 8) chk("rise_out_e8", 0, dout[0], 1'b0);
            if (k == 9) begin
                chk("rise_e9", 0, drise[0], 1'b1);
                chk("rise_out_e9", 0, dout[0], 1'b1);
                chk("rise_busy_e9", 0, dbusy[0], 1'b0);
            end
            if (k == 10) chk("rise_one_cycle", 0, drise[0], 1'b0);
        end
        din[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) chk("fall_e9", 0, dfall[0], 1'b1);
        end

        // Short glitch
        din[0] = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        din[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("glitch_out", 0, dout[0], 1'b0);
        end

        // Input drops exactly on the would-be commit edge
        din[0] = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        din[0] = 1'b0;
        step();
        chk("late_glitch_out", 0, dout[0], 1'b0);
        chk("late_glitch_rise", 0, drise[0], 1'b0);
        chk("late_glitch_busy", 0, dbusy[0], 1'b0);
        step();

        // Reset mid-CHECK
        din[0] = 1'b1;
        for (int k = 1; k <= 3; k++) step();
        reset = 1'b1;
        step();
        chk("midrst_busy", 0, dbusy[0], 1'b0);
        chk("midrst_out", 0, dout[0], 1'b0);
        chk("midrst_rise", 0, drise[0], 1'b0);
        reset  = 1'b0;
        din[0] = 1'b0;
        step();

        // Tick gating on HOLD=4: raise out first, then fall with tick every 4th cycle
        din[1] = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        din[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tck[1] = (k % 4 == 0);
            step();
            if (k == 15) chk("tick_out_e15", 1, dout[1], 1'b1);
            if (k == 16) chk("tick_fall_e16", 1, dfall[1], 1'b1);
        end
        tck[1] = 1'b1;

        // HOLD=1 follows on the second edge
        din[2] = 1'b1;
        step();
        chk("h1_out_e1", 2, dout[2], 1'b0);
        step();
        chk("h1_out_e2", 2, dout[2], 1'b1);
        chk("h1_rise_e2", 2, drise[2], 1'b1);
        din[2] = 1'b0;
        step();
        step();
        chk("h1_fall_e2", 2, dfall[2], 1'b1);

        // RSTVAL=1 instance falls on a held low input
        din[3] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 4) chk("r1_fall_e4", 3, dfall[3], 1'b1);
            chk("r1_no_rise", 3, drise[3], 1'b0);
        end

        // Random input stream, gated tick on the last instance only
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(5) == 0) din[i] = ~din[i];
            tck = {1'($urandom_range(1)), 3'b111};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
